// File: rtl/alpha_window_lifo.sv
// alpha_window_lifo
// Captures a window of forward (alpha) state metrics from a trellis decoder and
// hands them back in reverse order to the LLR stage. Each entry stores the 7
// non-zero-state metrics plus the Razor timing-error tag seen with them.
//
// The block alternates between two phases:
//   FILL  : every alpha_valid writes one entry. The window closes when W entries
//           are stored or a write carries alpha_last.
//   DRAIN : each rd_req pops the newest entry onto alpha_out one cycle later.
//           The pop that empties the store returns the block to FILL.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   alpha_in        7 x M signed metrics, state s at bits [(s-1)*M +: M], s = 1..7
//   alpha_valid     alpha_in / err_in valid
//   alpha_last      final step of a short window (qualified by alpha_valid)
//   err_in          Razor timing-error flag aligned with alpha_in
//   rd_req          downstream request for the next stored vector
//   alpha_out       stored vector, reverse write order (holds between reads)
//   alpha_out_valid one-cycle strobe per accepted read
//   err_out         Razor tag stored with the vector on alpha_out
//   full            window captured, drain phase active
//   empty           no stored entries
//   overflow        sticky: a write arrived during DRAIN and was dropped
module alpha_window_lifo #(
  parameter int unsigned M = 6,
  parameter int unsigned W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7*M-1:0]   alpha_in,
  input  logic             alpha_valid,
  input  logic             alpha_last,
  input  logic             err_in,
  input  logic             rd_req,
  output logic [7*M-1:0]   alpha_out,
  output logic             alpha_out_valid,
  output logic             err_out,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(W);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 7 * M + 1;

  localparam logic [CW-1:0] Depth = CW'(W);
  localparam logic [CW-1:0] One   = CW'(1);

  typedef enum logic [0:0] {
    StFill,
    StDrain
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] cnt_dec;

  // Storage has no reset: entries above cnt are never read, so stale contents
  // left by a reset are harmless until overwritten.
  logic [EW-1:0] mem_q [W];

  assign cnt_inc = cnt_q + One;
  assign cnt_dec = cnt_q - One;
  assign wr_idx  = cnt_q[AW-1:0];
  assign rd_idx  = cnt_dec[AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;

    unique case (state_q)
      StFill: begin
        // rd_req is ignored while filling; alpha_last alone is ignored too.
        if (alpha_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_inc;
          if ((cnt_inc == Depth) || alpha_last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Writes during drain are dropped, including one coinciding with the
        // final read; only the sticky flag records them.
        if (alpha_valid) begin
          ovf_d = 1'b1;
        end
        if (rd_req && (cnt_q != '0)) begin
          rd_en = 1'b1;
          cnt_d = cnt_dec;
          if (cnt_q == One) begin
            state_d = StFill;
          end
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StFill;
      cnt_q           <= '0;
      ovf_q           <= 1'b0;
      alpha_out       <= '0;
      err_out         <= 1'b0;
      alpha_out_valid <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ovf_q           <= ovf_d;
      alpha_out_valid <= rd_en;
      if (rd_en) begin
        {alpha_out, err_out} <= mem_q[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[wr_idx] <= {alpha_in, err_in};
    end
  end

  assign full     = (state_q == StDrain);
  assign empty    = (cnt_q == '0);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alpha_window_lifo.sv
// Self-checking bench for alpha_window_lifo: directed window scenarios checked
// against constants, then randomized traffic checked against a stack model.
module tb_alpha_window_lifo;

  localparam int unsigned M = 6;
  localparam int unsigned W = 16;
  localparam int unsigned VW = 7 * M;

  logic          clk;
  logic          rst;
  logic [VW-1:0] alpha_in;
  logic          alpha_valid;
  logic          alpha_last;
  logic          err_in;
  logic          rd_req;
  logic [VW-1:0] alpha_out;
  logic          alpha_out_valid;
  logic          err_out;
  logic          full;
  logic          empty;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a stack of {vector, tag} plus a drain flag.
  logic [VW:0]   m_q[$];
  logic          m_drain = 1'b0;
  logic          m_ovf = 1'b0;
  logic [VW-1:0] m_out = '0;
  logic          m_err = 1'b0;
  logic          m_valid = 1'b0;

  alpha_window_lifo #(
    .M(M),
    .W(W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alpha_in       (alpha_in),
    .alpha_valid    (alpha_valid),
    .alpha_last     (alpha_last),
    .err_in         (err_in),
    .rd_req         (rd_req),
    .alpha_out      (alpha_out),
    .alpha_out_valid(alpha_out_valid),
    .err_out        (err_out),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector whose metric for state s is k+s.
  function automatic logic [VW-1:0] mkvec(input int k);
    logic [VW-1:0] v;
    for (int s = 1; s <= 7; s++) v[(s-1)*M +: M] = M'(k + s);
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input logic [VW-1:0] a, input logic v, input logic l,
                      input logic e, input logic r, input logic rs);
    alpha_in    = a;
    alpha_valid = v;
    alpha_last  = l;
    err_in      = e;
    rd_req      = r;
    rst         = rs;
    m_valid = 1'b0;
    if (rs) begin
      m_q.delete();
      m_drain = 1'b0;
      m_ovf   = 1'b0;
      m_out   = '0;
      m_err   = 1'b0;
    end else if (!m_drain) begin
      if (v) begin
        m_q.push_back({a, e});
        if (m_q.size() == W || l) m_drain = 1'b1;
      end
    end else begin
      if (v) m_ovf = 1'b1;
      if (r && m_q.size() > 0) begin
        {m_out, m_err} = m_q.pop_back();
        m_valid = 1'b1;
        if (m_q.size() == 0) m_drain = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    // Reset dominates simultaneous write and read requests.
    step(mkvec(3), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(mkvec(4), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if ({full, empty, overflow, alpha_out_valid, err_out} !== 5'b01000 || alpha_out !== '0) begin
      n_bad++;
      $display("FAIL reset: full/empty/ovf/valid/err=%b out=%h, required 01000 out=0",
               {full, empty, overflow, alpha_out_valid, err_out}, alpha_out);
    end
  endtask

  task automatic test_full_window();
    for (int k = 0; k < 16; k++) begin
      step(mkvec(k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 14) begin
        n_cmp++;
        if (full !== 1'b0) begin
          n_bad++;
          $display("FAIL full_early: full=%b required 0 after 15 writes", full);
        end
      end
    end
    n_cmp++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      n_bad++;
      $display("FAIL full_set: full=%b empty=%b required 1 0", full, empty);
    end
    for (int j = 0; j < 16; j++) begin
      step('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (alpha_out_valid !== 1'b1 || alpha_out !== mkvec(15 - j) || err_out !== 1'b0) begin
        n_bad++;
        $display("FAIL full_read%0d: valid=%b out=%h err=%b required 1 %h 0",
                 j, alpha_out_valid, alpha_out, err_out, mkvec(15 - j));
      end
    end
    idle();
    n_cmp++;
    if (empty !== 1'b1 || full !== 1'b0 || alpha_out_valid !== 1'b0 || alpha_out !== mkvec(0)) begin
      n_bad++;
      $display("FAIL full_after: empty=%b full=%b valid=%b out=%h required 1 0 0 %h",
               empty, full, alpha_out_valid, alpha_out, mkvec(0));
    end
  endtask

  task automatic test_short_window();
    for (int k = 0; k < 5; k++) step(mkvec(k + 20), 1'b1, (k == 4), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (full !== 1'b1) begin
      n_bad++;
      $display("FAIL short_full: full=%b required 1", full);
    end
    for (int j = 0; j < 5; j++) begin
      step('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (alpha_out_valid !== 1'b1 || alpha_out !== mkvec(24 - j)) begin
        n_bad++;
        $display("FAIL short_read%0d: valid=%b out=%h required 1 %h",
                 j, alpha_out_valid, alpha_out, mkvec(24 - j));
      end
    end
    step('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (alpha_out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
      n_bad++;
      $display("FAIL short_extra: valid=%b empty=%b full=%b required 0 1 0",
               alpha_out_valid, empty, full);
    end
  endtask

  task automatic test_err_tag();
    // A lone alpha_last without alpha_valid must not close the window.
    step('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(mkvec(k), 1'b1, (k == 7), (k == 3), 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      step('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (alpha_out !== mkvec(7 - j) || err_out !== (j == 4)) begin
        n_bad++;
        $display("FAIL err_read%0d: out=%h err=%b required %h %b",
                 j, alpha_out, err_out, mkvec(7 - j), (j == 4));
      end
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 4; k++) step(mkvec(k + 10), 1'b1, (k == 3), 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      // Writes on the 2nd and final read cycles are dropped.
      step(mkvec(40), (j == 1 || j == 3), 1'b0, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (alpha_out_valid !== 1'b1 || alpha_out !== mkvec(13 - j) || err_out !== 1'b0) begin
        n_bad++;
        $display("FAIL ovf_read%0d: valid=%b out=%h err=%b required 1 %h 0",
                 j, alpha_out_valid, alpha_out, err_out, mkvec(13 - j));
      end
    end
    n_cmp++;
    if (overflow !== 1'b1 || empty !== 1'b1 || full !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_flag: ovf=%b empty=%b full=%b required 1 1 0", overflow, empty, full);
    end
    step(mkvec(30), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mkvec(31), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (alpha_out !== mkvec(30) || err_out !== 1'b0 || overflow !== 1'b1 || empty !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_next: out=%h err=%b ovf=%b empty=%b required %h 0 1 1",
               alpha_out, err_out, overflow, empty, mkvec(30));
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 6; k++) step(mkvec(k), 1'b1, (k == 5), 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) step(mkvec(50), (j == 0), 1'b0, 1'b0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if ({empty, full, alpha_out_valid, overflow} !== 4'b1000) begin
      n_bad++;
      $display("FAIL rst_mid: empty/full/valid/ovf=%b required 1000",
               {empty, full, alpha_out_valid, overflow});
    end
    step(mkvec(60), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mkvec(61), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 2; j++) begin
      step('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (alpha_out_valid !== 1'b1 || alpha_out !== mkvec(61 - j)) begin
        n_bad++;
        $display("FAIL rst_new%0d: valid=%b out=%h required 1 %h",
                 j, alpha_out_valid, alpha_out, mkvec(61 - j));
      end
    end
  endtask

  task automatic test_negative();
    logic [VW-1:0] v;
    v = VW'($urandom);
    v[6*M +: M] = 6'b100000;  // -32
    v[0 +: M]   = 6'b011111;  // 31
    step(v, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (alpha_out !== v || err_out !== 1'b1) begin
      n_bad++;
      $display("FAIL negative: out=%h err=%b required %h 1", alpha_out, err_out, v);
    end
  endtask

  task automatic test_random();
    step('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      step(VW'({$urandom, $urandom}), ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 199) == 0));
      n_cmp++;
      if (alpha_out_valid !== m_valid || alpha_out !== m_out || err_out !== m_err ||
          full !== m_drain || empty !== (m_q.size() == 0) || overflow !== m_ovf) begin
        n_bad++;
        $display("FAIL random%0d: v=%b out=%h e=%b f=%b em=%b o=%b required %b %h %b %b %b %b",
                 i, alpha_out_valid, alpha_out, err_out, full, empty, overflow,
                 m_valid, m_out, m_err, m_drain, (m_q.size() == 0), m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_short_window();
    test_err_tag();
    test_overflow();
    test_reset_mid_drain();
    test_negative();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
